// File: rtl/rule110_pkg.sv
// Shared state type and default sizes for the Rule 110 run controller.
// Fixed-point detection is enabled by defining RULE110_FIXPT_DETECT_EN.
package rule110_pkg;

   localparam int DEF_WIDTH = 512;
   localparam int DEF_GEN_W = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      RUN    = 2'd2,
      FINISH = 2'd3
   } state_e;

   function automatic logic isBusy(input state_e s);
      return (s != IDLE);
   endfunction

endpackage

// File: rtl/rule110_run_ctrl_if.sv
// Host-side start/done handshake of the Rule 110 run controller.
// The host drives the master modport, the controller sits on the slave modport.
interface rule110_run_ctrl_if #(
   parameter int WIDTH = rule110_pkg::DEF_WIDTH,
   parameter int GEN_W = rule110_pkg::DEF_GEN_W
);

   logic             start;
   logic             abort;
   logic [WIDTH-1:0] seed;
   logic [GEN_W-1:0] gen_count;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic [GEN_W-1:0] gens_run;
   logic             fixpt;

   modport master (
      output start, abort, seed, gen_count,
      input  busy, done, result, gens_run, fixpt
   );

   modport slave (
      input  start, abort, seed, gen_count,
      output busy, done, result, gens_run, fixpt
   );

endinterface

// File: rtl/rule110_fixpt_det.sv
// Fixed-point detector: flags a RUN cycle whose engine state equals the previous one.
// Instantiated by the controller only when RULE110_FIXPT_DETECT_EN is defined.
module rule110_fixpt_det
   import rule110_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int GEN_W = DEF_GEN_W
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             runActive_i,
   input  logic [GEN_W-1:0] count_i,
   input  logic [WIDTH-1:0] engQ_i,
   output logic             hit_o
);

   logic [WIDTH-1:0] prev_q;

   // prev_q holds the generation seen in the previous RUN cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q <= '0;
      end else if (runActive_i) begin
         prev_q <= engQ_i;
      end
   end

   // The first RUN cycle has no valid predecessor, hence the count qualifier.
   assign hit_o = runActive_i && (count_i != '0) && (engQ_i == prev_q);

endmodule

// File: rtl/rule110_run_ctrl.sv
// Run controller for the Rule 110 engine: load a seed, run N generations, freeze, publish.
// Optional early stop on a fixed point is enabled by defining RULE110_FIXPT_DETECT_EN.
module rule110_run_ctrl
   import rule110_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int GEN_W = DEF_GEN_W
)(
   input  logic             clk,
   input  logic             rst_n,
   rule110_run_ctrl_if.slave host,
   output logic             eng_load,
   output logic [WIDTH-1:0] eng_data,
   input  logic [WIDTH-1:0] eng_q
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] seed_q, seed_d;
   logic [GEN_W-1:0] capN_q, capN_d;
   logic [GEN_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [GEN_W-1:0] gensRun_q, gensRun_d;
   logic             done_q, done_d;
   logic             fixHit;
   logic             hitSeen;

`ifdef RULE110_FIXPT_DETECT_EN
   logic hitSeen_q, hitSeen_d;
   logic fixpt_q, fixpt_d;

   rule110_fixpt_det #(
      .WIDTH (WIDTH),
      .GEN_W (GEN_W)
   ) u_fixpt_det (
      .clk         (clk),
      .rst_n       (rst_n),
      .runActive_i (state_q == RUN),
      .count_i     (count_q),
      .engQ_i      (eng_q),
      .hit_o       (fixHit)
   );

   // hitSeen remembers that the run left RUN early, so FINISH reports it.
   always_comb begin
      hitSeen_d = hitSeen_q;
      fixpt_d   = fixpt_q;
      if (state_q == IDLE && host.start) begin
         fixpt_d = 1'b0;
      end
      if (state_q == LOAD) begin
         hitSeen_d = 1'b0;
      end
      if (state_q == RUN && !host.abort && fixHit) begin
         hitSeen_d = 1'b1;
      end
      if (state_q == FINISH && !host.abort) begin
         fixpt_d = hitSeen_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hitSeen_q <= 1'b0;
         fixpt_q   <= 1'b0;
      end else begin
         hitSeen_q <= hitSeen_d;
         fixpt_q   <= fixpt_d;
      end
   end

   assign hitSeen    = hitSeen_q;
   assign host.fixpt = fixpt_q;
`else
   assign fixHit     = 1'b0;
   assign hitSeen    = 1'b0;
   assign host.fixpt = 1'b0;
`endif

   // Outside LOAD/RUN the engine reloads its own q, which freezes it.
   always_comb begin
      state_d   = state_q;
      seed_d    = seed_q;
      capN_d    = capN_q;
      count_d   = count_q;
      result_d  = result_q;
      gensRun_d = gensRun_q;
      done_d    = 1'b0;
      eng_load  = 1'b1;
      eng_data  = eng_q;

      unique case (state_q)
         IDLE: begin
            if (host.start) begin
               seed_d  = host.seed;
               capN_d  = host.gen_count;
               state_d = LOAD;
            end
         end

         LOAD: begin
            eng_data = seed_q;
            if (host.abort) begin
               state_d = IDLE;
            end else if (capN_q == '0) begin
               state_d = FINISH;
            end else begin
               count_d = '0;
               state_d = RUN;
            end
         end

         RUN: begin
            eng_load = 1'b0;
            eng_data = seed_q;
            if (host.abort) begin
               state_d = IDLE;
            end else begin
               count_d = count_q + GEN_W'(1);
               if (fixHit || (count_q == capN_q - GEN_W'(1))) begin
                  state_d = FINISH;
               end
            end
         end

         FINISH: begin
            if (host.abort) begin
               state_d = IDLE;
            end else begin
               result_d  = eng_q;
               gensRun_d = hitSeen ? count_q : capN_q;
               done_d    = 1'b1;
               state_d   = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         seed_q    <= '0;
         capN_q    <= '0;
         count_q   <= '0;
         result_q  <= '0;
         gensRun_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         seed_q    <= seed_d;
         capN_q    <= capN_d;
         count_q   <= count_d;
         result_q  <= result_d;
         gensRun_q <= gensRun_d;
         done_q    <= done_d;
      end
   end

   assign host.busy     = isBusy(state_q);
   assign host.done     = done_q;
   assign host.result   = result_q;
   assign host.gens_run = gensRun_q;

endmodule

// File: tb/tb_rule110_run_ctrl.sv
// Bench for rule110_run_ctrl wired to a Rule 110 engine model with zero boundaries.
// Expected results come from a per-cell rule-table model; honours RULE110_FIXPT_DETECT_EN.
module tb_rule110_run_ctrl;

   localparam int WIDTH = 64;
   localparam int GEN_W = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             engLoad;
   logic [WIDTH-1:0] engData;
   logic [WIDTH-1:0] engQ;

   int compared   = 0;
   int mismatched = 0;

   logic [WIDTH-1:0] lastRes;
   int               lastGens;
   bit               lastFix;

   rule110_run_ctrl_if #(.WIDTH(WIDTH), .GEN_W(GEN_W)) hostIf ();

   rule110_run_ctrl #(
      .WIDTH (WIDTH),
      .GEN_W (GEN_W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .host     (hostIf),
      .eng_load (engLoad),
      .eng_data (engData),
      .eng_q    (engQ)
   );

   always #5 clk = ~clk;

   // Engine: capture data when load is high, otherwise advance one generation.
   always @(posedge clk) begin
      if (engLoad) begin
         engQ <= engData;
      end else begin
         engQ <= (engQ | (engQ << 1)) & ~((engQ >> 1) & engQ & (engQ << 1));
      end
   end

   task automatic checkOutput(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // One generation computed cell by cell from the rule number.
   function automatic logic [WIDTH-1:0] refStep(input logic [WIDTH-1:0] q);
      logic [7:0]       ruleTable;
      logic [WIDTH-1:0] nxt;
      logic             l, c, r;
      ruleTable = 8'd110;
      nxt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         l = (i == WIDTH - 1) ? 1'b0 : q[i+1];
         c = q[i];
         r = (i == 0) ? 1'b0 : q[i-1];
         nxt[i] = ruleTable[{l, c, r}];
      end
      return nxt;
   endfunction

   task automatic refRun(input logic [WIDTH-1:0] s, input int n, output logic [WIDTH-1:0] res,
                         output int gens, output bit fix, output int lat);
      logic [WIDTH-1:0] cur, prev;
      cur  = s;
      prev = s;
      fix  = 1'b0;
      gens = n;
      lat  = n + 3;
      for (int c = 0; c < n; c++) begin
`ifdef RULE110_FIXPT_DETECT_EN
         if (c >= 1 && cur == prev) begin
            fix  = 1'b1;
            gens = c + 1;
            res  = cur;
            lat  = c + 4;
            return;
         end
`endif
         prev = cur;
         cur  = refStep(cur);
      end
      res = cur;
   endtask

   function automatic logic [WIDTH-1:0] randVec();
      logic [WIDTH-1:0] v;
      v = '0;
      for (int i = 0; i < WIDTH; i += 32) begin
         v = (v << 32) | WIDTH'($urandom);
      end
      return v;
   endfunction

   task automatic applyStimulus(input logic [WIDTH-1:0] s, input int n);
      hostIf.seed      = s;
      hostIf.gen_count = GEN_W'(n);
      hostIf.start     = 1'b1;
   endtask

   // Called in the cycle where start is driven; walks the run cycle by cycle.
   task automatic waitRun(input logic [WIDTH-1:0] s, input int n, input int abortAtIn,
                          input int pokeAt, input bit keepStart);
      logic [WIDTH-1:0] expRes, frozenQ;
      int               expGens, expLat, lowCnt, doneAt, abortAt;
      bit               expFix;
      refRun(s, n, expRes, expGens, expFix, expLat);
      abortAt = (abortAtIn < expLat) ? abortAtIn : 0;
      lastFix = 1'b0;
      lowCnt  = 0;
      doneAt  = 0;
      for (int k = 1; k <= expLat; k++) begin
         stepCycle();
         hostIf.abort = 1'b0;
         if (!keepStart) hostIf.start = 1'b0;
         if (k == pokeAt) begin
            hostIf.start     = 1'b1;
            hostIf.seed      = ~s;
            hostIf.gen_count = GEN_W'(n + 1);
         end
         if (!engLoad) lowCnt++;
         if (hostIf.done && doneAt == 0) doneAt = k;
         if (k == 1) checkOutput("busyAfterStart", WIDTH'(hostIf.busy), WIDTH'(1));
         if (abortAt != 0 && k == abortAt + 1) begin
            checkOutput("abortBusy", WIDTH'(hostIf.busy), WIDTH'(0));
            checkOutput("abortDone", WIDTH'(hostIf.done), WIDTH'(0));
            checkOutput("abortResult", hostIf.result, lastRes);
            checkOutput("abortGens", WIDTH'(hostIf.gens_run), WIDTH'(lastGens));
            checkOutput("abortFixpt", WIDTH'(hostIf.fixpt), WIDTH'(lastFix));
            frozenQ = engQ;
            repeat (3) stepCycle();
            checkOutput("abortFrozen", engQ, frozenQ);
            checkOutput("abortNoDoneLater", WIDTH'(hostIf.done), WIDTH'(0));
            return;
         end
         if (k == abortAt) hostIf.abort = 1'b1;
         if (k == expLat - 1) checkOutput("busyBeforeDone", WIDTH'(hostIf.busy), WIDTH'(1));
         if (k == expLat) begin
            checkOutput("doneCycle", WIDTH'(doneAt), WIDTH'(expLat));
            checkOutput("busyAtDone", WIDTH'(hostIf.busy), WIDTH'(0));
            checkOutput("result", hostIf.result, expRes);
            checkOutput("gensRun", WIDTH'(hostIf.gens_run), WIDTH'(expGens));
            checkOutput("fixpt", WIDTH'(hostIf.fixpt), WIDTH'(expFix));
            checkOutput("gensApplied", WIDTH'(lowCnt), WIDTH'(expGens));
            checkOutput("engLoadAtDone", WIDTH'(engLoad), WIDTH'(1));
         end
      end
      lastRes  = expRes;
      lastGens = expGens;
      lastFix  = expFix;
      if (!keepStart) begin
         stepCycle();
         checkOutput("donePulseEnds", WIDTH'(hostIf.done), WIDTH'(0));
         checkOutput("idleAfterDone", WIDTH'(hostIf.busy), WIDTH'(0));
      end
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "Busy"}, WIDTH'(hostIf.busy), WIDTH'(0));
      checkOutput({tag, "Done"}, WIDTH'(hostIf.done), WIDTH'(0));
      checkOutput({tag, "Result"}, hostIf.result, WIDTH'(0));
      checkOutput({tag, "Gens"}, WIDTH'(hostIf.gens_run), WIDTH'(0));
      checkOutput({tag, "Fixpt"}, WIDTH'(hostIf.fixpt), WIDTH'(0));
      checkOutput({tag, "EngLoad"}, WIDTH'(engLoad), WIDTH'(1));
      lastRes  = '0;
      lastGens = 0;
      lastFix  = 1'b0;
   endtask

   initial begin
      logic [WIDTH-1:0] s;
      int               n, mode, abortAt;

      rst_n            = 1'b0;
      hostIf.start     = 1'b0;
      hostIf.abort     = 1'b0;
      hostIf.seed      = '0;
      hostIf.gen_count = '0;
      repeat (2) stepCycle();
      checkResetState("reset");
      rst_n = 1'b1;
      stepCycle();

      applyStimulus(WIDTH'(1), 3);
      waitRun(WIDTH'(1), 3, 0, 0, 1'b0);
      checkOutput("seed1N3Is13", hostIf.result, WIDTH'(13));

      applyStimulus(WIDTH'(1), 0);
      waitRun(WIDTH'(1), 0, 0, 0, 1'b0);

      applyStimulus(WIDTH'(1), 100);
      waitRun(WIDTH'(1), 100, 10, 0, 1'b0);

      applyStimulus(WIDTH'(1), 20);
      waitRun(WIDTH'(1), 20, 0, 5, 1'b0);

      s = randVec();
      applyStimulus(s, 7);
      waitRun(s, 7, 0, 0, 1'b1);
      waitRun(s, 7, 0, 0, 1'b0);

      applyStimulus(WIDTH'(0), 100);
      waitRun(WIDTH'(0), 100, 0, 0, 1'b0);

      hostIf.abort = 1'b1;
      stepCycle();
      hostIf.abort = 1'b0;
      checkOutput("idleAbortBusy", WIDTH'(hostIf.busy), WIDTH'(0));
      hostIf.abort = 1'b1;
      applyStimulus(WIDTH'(1), 5);
      waitRun(WIDTH'(1), 5, 0, 0, 1'b0);

      applyStimulus(WIDTH'(1), 2);
      waitRun(WIDTH'(1), 2, 4, 0, 1'b0);
      applyStimulus(WIDTH'(5), 5);
      waitRun(WIDTH'(5), 5, 1, 0, 1'b0);

      applyStimulus(WIDTH'(1), (1 << GEN_W) - 1);
      waitRun(WIDTH'(1), (1 << GEN_W) - 1, 0, 0, 1'b0);

      applyStimulus(WIDTH'(1), 50);
      repeat (4) begin
         stepCycle();
         hostIf.start = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      checkResetState("midRunReset");
      stepCycle();
      rst_n = 1'b1;
      stepCycle();
      applyStimulus(WIDTH'(1), 3);
      waitRun(WIDTH'(1), 3, 0, 0, 1'b0);

      for (int it = 0; it < 24; it++) begin
         mode    = $urandom_range(0, 3);
         n       = $urandom_range(0, 40);
         s       = (mode == 3) ? (WIDTH'(1) << $urandom_range(0, WIDTH - 1)) : randVec();
         abortAt = (mode == 0) ? $urandom_range(1, 45) : 0;
         applyStimulus(s, n);
         waitRun(s, n, abortAt, 0, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/rule110_run_ctrl.md
Name: rule110_run_ctrl

Overview:
Run controller for the Rule 110 cellular-automaton engine (`des`: `clk`, `load`, `data`, `q`). The engine has no enable: with `load=1` it captures `data`; with `load=0` it advances one generation per clock.
This block accepts a seed and a generation count through a start/done handshake, loads the engine, lets it run exactly N generations, then freezes it and publishes the result.
The block sits between the host/testbench and the engine. The engine stays a separate instance, wired through the eng_* ports.

Parameters:
WIDTH, 512, cell-array width; must match the engine.
GEN_W, 16, width of the generation count.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset, asynchronous assert, active-low.
start  in  1  request a run; sampled only in IDLE.
abort  in  1  synchronous cancel of a run in progress.
seed  in  WIDTH  initial generation; captured when start is accepted.
gen_count  in  GEN_W  generations to run (N); captured with seed.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse; result valid.
result  out  WIDTH  engine state after the run; held until next done.
gens_run  out  GEN_W  generations actually applied in the last run.
fixpt  out  1  last run ended on a fixed point (optional feature; else 0).
eng_load  out  1  drives engine load.
eng_data  out  WIDTH  drives engine data.
eng_q  in  WIDTH  engine q.

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE; result=0, gens_run=0, done=0, fixpt=0.
  - Internal counter and captured seed/count = 0.
- States: IDLE, LOAD, RUN, FINISH.
- Engine drive by state:
  - IDLE, FINISH: eng_load=1, eng_data=eng_q. The engine reloads its own state, so it is frozen.
  - LOAD: eng_load=1, eng_data=captured seed.
  - RUN: eng_load=0, eng_data=captured seed (don't-care value, fixed to avoid toggling).
  - The eng_q to eng_data path is combinational; there is no register in it.
- Transitions:
  - IDLE with start=1: capture seed and gen_count, go to LOAD.
  - LOAD: if captured N=0, go to FINISH; else clear counter, go to RUN.
  - RUN: counter increments each cycle. When counter == N-1 at the edge, go to FINISH. The engine has then applied exactly N generations.
  - FINISH: result <= eng_q, gens_run <= N, done <= 1 (registered), go to IDLE.
- done is high the cycle after FINISH, for exactly one cycle.
- Latency: start accepted in cycle T, done high in cycle T+3+N (N=0 gives T+3).
- busy = (state != IDLE). In cycle T+3+N busy=0 and done=1.
- start while busy: ignored, not queued.
- start in the same cycle done is high: accepted, since state is IDLE.
- abort in LOAD, RUN or FINISH:
  - Go to IDLE next cycle.
  - No done pulse; result, gens_run and fixpt unchanged.
  - Engine frozen from the IDLE cycle onward.
- abort has priority over completion, including in the FINISH cycle.
- abort in IDLE: no effect. abort together with start in IDLE: the start is accepted.
- Counter: GEN_W bits; N=2^GEN_W-1 is legal, and the compare prevents wrap.
- Reset mid-run: immediate return to IDLE with all outputs at reset values. Engine contents are undefined until the next LOAD.

Optional Feature:
Macro RULE110_FIXPT_DETECT_EN.
- Defined:
  - Register prev_q <= eng_q every RUN cycle.
  - In a RUN cycle with counter>=1 and eng_q==prev_q (a fixed point), go to FINISH early.
  - gens_run = counter+1 (generations applied); fixpt=1 with the done pulse.
  - fixpt is cleared at the next start accepted.
  - A normal count-out sets fixpt=0.
- Not defined: no comparator, no prev_q register; fixpt tied 0; runs always last N generations.

Decomposition:
- Package rule110_pkg:
  - state enum (IDLE, LOAD, RUN, FINISH).
  - Default WIDTH=512 and GEN_W=16 constants.
- One natural sub-module: rule110_fixpt_det, holding prev_q, the counter>=1 qualifier and the equality compare. It is instantiated only under RULE110_FIXPT_DETECT_EN.
- The engine is not instantiated inside this block. Benches wire controller and engine together.

Test Plan:
All scenarios use controller + engine with cell i next = f(q[i+1], q[i], q[i-1]) and zero boundaries.
1. seed=1, N=3, start at T -> busy=1 from T+1 to T+5; done=1 at T+6; result=13 (0b1101); gens_run=3; eng_load=1 from T+6 onward.
2. seed=1, N=0 -> done at T+3; result=1; gens_run=0; engine never sees eng_load=0.
3. seed=1, N=100; abort asserted at T+10 -> busy=0 at T+11; no done; result and gens_run keep prior values; eng_q constant from T+11.
4. start pulsed while busy, and start held high through done -> mid-run starts ignored; the new run begins the cycle done is high (busy=1 next cycle).
5. seed=0, N=100 -> with RULE110_FIXPT_DETECT_EN: done at T+5, gens_run=2, fixpt=1, result=0. Without the macro: done at T+103, gens_run=100, fixpt=0.
6. rst_n pulled low at T+4 of a seed=1, N=50 run -> busy, done, result, gens_run all 0 immediately; a fresh start after release behaves as in scenario 1.
